// File: rtl/uart_pkg.sv
// Shared types for the UART TX arbiter.
// Optional header stage: UART_ARB_HDR_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE
    } state_e;

    localparam logic [3:0] HDR_MAGIC = 4'hA;

    function automatic logic [7:0] hdr_byte(input logic [3:0] id);
        return {HDR_MAGIC, id};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester
// after the pointer (wrapping) wins.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);

    // scan ptr+1 .. ptr+NREQ, keep the first hit
    always_comb begin
        int j;
        gnt = '0;
        idx = '0;
        j   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (gnt == '0 && req[j]) begin
                gnt[j] = 1'b1;
                idx    = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NREQ byte streams.
// Define UART_ARB_HDR_EN to prefix each burst with a header byte.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NREQ      = 4,
    parameter  int BURST_MAX = 16,
    localparam int IDW       = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx_start,
    output logic [7:0]        tx_byte,
    input  logic              tx_busy,
    output logic [IDW-1:0]    grant_id,
    output logic              grant_active
);

    localparam logic [7:0] CNT_MAX = 8'(BURST_MAX);

    state_e         state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic           active_q, active_d;
    logic           last_q, last_d;
    logic           start_q, start_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [7:0]     byte_q, byte_d;

    logic [NREQ-1:0] pick_gnt;
    logic [IDW-1:0]  pick_idx;
    logic            sel_valid;
    logic            sel_last;
    logic [7:0]      sel_data;
    logic            rel_now;

    rr_arbiter #(
        .NREQ(NREQ),
        .IDW (IDW)
    ) u_rr (
        .req(req_valid),
        .ptr(ptr_q),
        .gnt(pick_gnt),
        .idx(pick_idx)
    );

    assign sel_valid = req_valid[grant_q];
    assign sel_last  = req_last[grant_q];
    assign sel_data  = req_data[8*grant_q +: 8];

    // next-state, handshake and release decisions
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        active_d  = active_q;
        last_d    = last_q;
        start_d   = 1'b0;
        cnt_d     = cnt_q;
        byte_d    = byte_q;
        req_ready = '0;
        rel_now   = 1'b0;
        unique case (state_q)
            IDLE: begin
                active_d = 1'b0;
                if (|pick_gnt) begin
                    grant_d  = pick_idx;
                    active_d = 1'b1;
                    cnt_d    = '0;
                    last_d   = 1'b0;
`ifdef UART_ARB_HDR_EN
                    state_d  = HDR;
`else
                    state_d  = ISSUE;
`endif
                end
            end
`ifdef UART_ARB_HDR_EN
            HDR: begin
                if (!tx_busy) begin
                    byte_d  = hdr_byte(4'(grant_q));
                    start_d = 1'b1;
                    last_d  = 1'b0;
                    state_d = WAIT_ACK;
                end
            end
`endif
            ISSUE: begin
                // a source that goes quiet gives up its slot
                if (!sel_valid) begin
                    rel_now = 1'b1;
                end else if (!tx_busy) begin
                    req_ready[grant_q] = 1'b1;
                    byte_d  = sel_data;
                    start_d = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                    last_d  = sel_last;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (last_q || cnt_q == CNT_MAX) begin
                        rel_now = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (rel_now) begin
            ptr_d    = grant_q;
            active_d = 1'b0;
            state_d  = IDLE;
        end
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            ptr_q    <= IDW'(NREQ - 1);
            active_q <= 1'b0;
            last_q   <= 1'b0;
            start_q  <= 1'b0;
            cnt_q    <= '0;
            byte_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            active_q <= active_d;
            last_q   <= last_d;
            start_q  <= start_d;
            cnt_q    <= cnt_d;
            byte_q   <= byte_d;
        end
    end

    assign tx_start     = start_q;
    assign tx_byte      = byte_q;
    assign grant_id     = grant_q;
    assign grant_active = active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (BURST_MAX=4).
// Honours UART_ARB_HDR_EN when expecting launches.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef struct {
        int sc; int id; logic [7:0] d; bit last; bit late;
    } in_t;
    typedef struct {
        int sc; int id; logic [7:0] d; bit first;
    } ex_t;
    typedef struct {
        int id; logic [7:0] d;
    } lg_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              tx_start;
    logic [7:0]        tx_byte;
    logic              tx_busy;
    logic [IDW-1:0]    grant_id;
    logic              grant_active;

    in_t  ins[$];
    ex_t  exs[$];
    lg_t  lg[$];
    int   lpos = 0;
    logic [8:0] q[NREQ][$];
    int   pops[NREQ];
    logic [NREQ-1:0] rs = '0;
    int   nvec = 0;
    int   nbad = 0;
    int   inv_bad = 0;
    int   busy_cnt = 0;
    logic prev_start = 1'b0;
    int   ld_req = 0;
    int   ld_ack = 0;
    int   ld_sc = 0;
    bit   ld_late = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NREQ     (NREQ),
        .BURST_MAX(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_byte     (tx_byte),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .grant_active(grant_active)
    );

    // UART model: busy from the cycle after tx_start, for 10 cycles
    assign tx_busy = (busy_cnt != 0);
    always @(posedge clk) begin
        if (tx_start === 1'b1) busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    // requester model: pop accepted bytes, apply queued loads
    always @(posedge clk) begin
        logic [8:0] h;
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (rs[i] && q[i].size() > 0) begin
                void'(q[i].pop_front());
                pops[i]++;
            end
        end
        if (ld_req != ld_ack) begin
            foreach (ins[k]) begin
                if (ins[k].sc == ld_sc && ins[k].late == ld_late)
                    q[ins[k].id].push_back({ins[k].last, ins[k].d});
            end
            ld_ack = ld_req;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (q[i].size() > 0) begin
                h = q[i][0];
                req_valid[i] = 1'b1;
                req_last[i]  = h[8];
                req_data[8*i +: 8] = h[7:0];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
                req_data[8*i +: 8] = 8'h00;
            end
        end
    end

    // monitor: log launches, watch handshake invariants
    always @(negedge clk) begin
        rs = req_ready;
        if (tx_start === 1'b1)
            lg.push_back('{int'(grant_id), tx_byte});
        if (prev_start === 1'b1 && tx_start === 1'b1)
            inv_bad++;
        if (req_ready !== '0) begin
            if (!$onehot(req_ready) ||
                req_ready !== (4'b1 << grant_id) ||
                grant_active !== 1'b1)
                inv_bad++;
        end
        prev_start = tx_start;
    end

    function automatic void ai(int sc, int id, int d,
                               bit last, bit late);
        in_t r;
        r.sc = sc; r.id = id; r.d = 8'(d);
        r.last = last; r.late = late;
        ins.push_back(r);
    endfunction

    function automatic void ae(int sc, int id, int d, bit first);
        ex_t r;
        r.sc = sc; r.id = id; r.d = 8'(d); r.first = first;
        exs.push_back(r);
    endfunction

    task automatic check(string nm, logic [31:0] act,
                         logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_launch(int sc, int id, logic [7:0] d);
        nvec++;
        if (lpos >= lg.size()) begin
            nbad++;
            $display("FAIL sc%0d launch %0d: none, want id%0d byte %02h",
                     sc, lpos, id, d);
        end else begin
            if (lg[lpos].id != id || lg[lpos].d !== d) begin
                nbad++;
                $display("FAIL sc%0d launch %0d: got id%0d byte %02h want id%0d byte %02h",
                         sc, lpos, lg[lpos].id, lg[lpos].d, id, d);
            end
            lpos++;
        end
    endtask

    task automatic compare(int sc);
        foreach (exs[k]) begin
            if (exs[k].sc == sc) begin
`ifdef UART_ARB_HDR_EN
                if (exs[k].first)
                    chk_launch(sc, exs[k].id, {4'hA, 4'(exs[k].id)});
`endif
                chk_launch(sc, exs[k].id, exs[k].d);
            end
        end
        check($sformatf("sc%0d launch count", sc), lg.size(), lpos);
        lpos = lg.size();
    endtask

    task automatic load(int sc, bit late);
        ld_sc   = sc;
        ld_late = late;
        ld_req++;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_pops(int id, int tgt, string nm);
        int n = 0;
        while (pops[id] < tgt && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({nm, " wait"}, 32'(n < 500), 1);
    endtask

    task automatic wait_busy(logic v, string nm);
        int n = 0;
        while (tx_busy !== v && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({nm, " wait"}, 32'(n < 500), 1);
    endtask

    task automatic drain(string nm);
        int  n = 0;
        bit  empty;
        do begin
            @(negedge clk);
            n++;
            empty = 1'b1;
            for (int i = 0; i < NREQ; i++)
                if (q[i].size() > 0) empty = 1'b0;
        end while (!(empty && grant_active === 1'b0 &&
                     tx_busy === 1'b0) && n < 3000);
        check({nm, " drain"}, 32'(n < 3000), 1);
    endtask

    task automatic reset_chk(string nm);
        check({nm, " tx_start"},     32'(tx_start), 0);
        check({nm, " tx_byte"},      32'(tx_byte), 0);
        check({nm, " req_ready"},    32'(req_ready), 0);
        check({nm, " grant_id"},     32'(grant_id), 0);
        check({nm, " grant_active"}, 32'(grant_active), 0);
    endtask

    initial begin
        int b0, b1, b2, b3;
        // stimulus and expected launch tables
        ai(1, 0, 'h10, 1, 0); ai(1, 1, 'h11, 1, 0);
        ai(1, 2, 'h12, 1, 0); ai(1, 3, 'h13, 1, 0);
        ae(1, 0, 'h10, 1); ae(1, 1, 'h11, 1);
        ae(1, 2, 'h12, 1); ae(1, 3, 'h13, 1);
        ai(2, 0, 'h20, 1, 0); ai(2, 0, 'h21, 1, 0);
        ai(2, 1, 'h30, 1, 0); ai(2, 1, 'h31, 1, 0);
        ai(2, 3, 'h40, 1, 0); ai(2, 3, 'h41, 1, 0);
        ae(2, 0, 'h20, 1); ae(2, 1, 'h30, 1); ae(2, 3, 'h40, 1);
        ae(2, 0, 'h21, 1); ae(2, 1, 'h31, 1); ae(2, 3, 'h41, 1);
        ai(3, 2, 'h55, 0, 0); ai(3, 2, 'hC3, 1, 0);
        ae(3, 2, 'h55, 1); ae(3, 2, 'hC3, 0);
        for (int k = 0; k < 10; k++) ai(4, 1, 'h80 + k, 0, 0);
        ai(4, 2, 'h92, 1, 0);
        for (int k = 0; k < 4; k++) ae(4, 1, 'h80 + k, k == 0);
        ae(4, 2, 'h92, 1);
        for (int k = 4; k < 8; k++) ae(4, 1, 'h80 + k, k == 4);
        ae(4, 1, 'h88, 1); ae(4, 1, 'h89, 0);
        ai(5, 2, 'hD0, 0, 0); ai(5, 2, 'hD1, 0, 0);
        ai(5, 2, 'hD2, 1, 0); ai(5, 1, 'hE1, 1, 1);
        ae(5, 2, 'hD0, 1); ae(5, 1, 'hE1, 1);
        ae(5, 2, 'hD1, 1); ae(5, 2, 'hD2, 0);
        ai(6, 0, 'hA0, 0, 0); ai(6, 0, 'hA1, 0, 0);
        for (int k = 0; k < 4; k++) ai(6, 3, 'hB0 + k, k == 3, 1);
        ae(6, 0, 'hA0, 1); ae(6, 0, 'hA1, 0);
        for (int k = 0; k < 4; k++) ae(6, 3, 'hB0 + k, k == 0);
        ai(7, 0, 'hF0, 1, 0); ai(7, 3, 'hF3, 1, 0);
        ae(7, 0, 'hF0, 1); ae(7, 3, 'hF3, 1);

        // reset held two cycles with every requester valid
        load(1, 0);
        @(negedge clk);
        reset_chk("reset c1");
        @(negedge clk);
        reset_chk("reset c2");
        rst = 1'b1;
        drain("sc1");
        compare(1);

        // round robin over 0,1,3
        load(2, 0);
        drain("sc2");
        compare(2);

        // single two-byte packet, release after second frame
        b2 = pops[2];
        load(3, 0);
        wait_pops(2, b2 + 2, "sc3 pops");
        wait_busy(1'b1, "sc3 busy rise");
        wait_busy(1'b0, "sc3 busy fall");
        check("sc3 active at busy fall", 32'(grant_active), 1);
        @(negedge clk);
        check("sc3 active after release", 32'(grant_active), 0);
        drain("sc3");
        compare(3);
        check("sc3 ready count", pops[2] - b2, 2);

        // burst cap forces rotation
        b1 = pops[1];
        load(4, 0);
        drain("sc4");
        compare(4);
        check("sc4 ready count", pops[1] - b1, 10);

        // reset in WAIT_DONE, pointer back to NREQ-1
        b2 = pops[2];
        load(5, 0);
        wait_pops(2, b2 + 1, "sc5 pops");
        wait_busy(1'b1, "sc5 busy rise");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        load(5, 1);
        @(negedge clk);
        reset_chk("sc5 mid reset");
        rst = 1'b1;
        drain("sc5");
        compare(5);

        // stall release, then last coinciding with cap
        b0 = pops[0];
        b3 = pops[3];
        load(6, 0);
        wait_pops(0, b0 + 1, "sc6 pops");
        load(6, 1);
        drain("sc6");
        compare(6);
        check("sc6 ready count 0", pops[0] - b0, 2);
        check("sc6 ready count 3", pops[3] - b3, 4);

        // pointer after combined release
        load(7, 0);
        drain("sc7");
        compare(7);

        check("handshake invariants", inv_bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nbad);
        $finish;
    end

endmodule
